// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, sequencer state encoding and op-decode helpers
// for the iterative multiply/divide unit.
// Optional build macro: MULDIV_SIGNED_DIV_EN (adds SDIV, op 4'b1110).
package muldiv_pkg;

  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_UMULL = 4'b0101;
  localparam logic [3:0] OP_SMULL = 4'b0110;
  localparam logic [3:0] OP_DIV   = 4'b0111;
  localparam logic [3:0] OP_SDIV  = 4'b1110;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [1:0] ST_FIX_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_RUN  = ST_RUN_ENC,
    ST_FIX  = ST_FIX_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

  // Op runs the restoring-divide iteration.
  function automatic logic op_is_div(input logic [3:0] op);
`ifdef MULDIV_SIGNED_DIV_EN
    return (op == OP_DIV) || (op == OP_SDIV);
`else
    return (op == OP_DIV);
`endif
  endfunction

  // Op works on operand magnitudes and needs a sign fix-up afterwards.
  function automatic logic op_is_signed(input logic [3:0] op);
`ifdef MULDIV_SIGNED_DIV_EN
    return (op == OP_SMULL) || (op == OP_SDIV);
`else
    return (op == OP_SMULL);
`endif
  endfunction

  // Op is executed by this unit at all.
  function automatic logic op_supported(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL) || op_is_div(op);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the sequencer datapath.
// Multiply: conditional add into the upper half, then shift {acc, sr} right.
// Divide: shift {rem, quo} left, restoring subtract when rem >= divisor.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_sr,
  input  logic [WIDTH-1:0] i_opd,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_sr
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_rem_sub;
  logic           w_ge;

  // Single shift-add or restoring-subtract step selected by i_div.
  always_comb begin
    w_sum     = i_acc + {1'b0, i_opd & {WIDTH{i_sr[0]}}};
    w_rem_sh  = {i_acc[WIDTH-1:0], i_sr[WIDTH-1]};
    w_rem_sub = w_rem_sh - {1'b0, i_opd};
    w_ge      = (w_rem_sh >= {1'b0, i_opd});
    o_acc     = {1'b0, w_sum[WIDTH:1]};
    o_sr      = {w_sum[0], i_sr[WIDTH-1:1]};
    if (i_div) begin
      o_acc = w_ge ? w_rem_sub : w_rem_sh;
      o_sr  = {i_sr[WIDTH-2:0], w_ge};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MUL/UMULL/SMULL/DIV sequencer, one bit per cycle.
// Optional build macro: MULDIV_SIGNED_DIV_EN adds SDIV (op 4'b1110);
// without it that op reports unsup.
//
//   state | meaning
//   IDLE  | waiting for start; latches op/operands on an accepted start
//   RUN   | WIDTH shift-add / restoring-subtract iterations
//   FIX   | sign fix-up, divide-by-zero results, flag computation
//   DONE  | results registered, done pulses for one cycle
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero,
  output logic             unsup,
  output logic             flag_n,
  output logic             flag_z
);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_sr;
  logic [WIDTH-1:0]   r_opd;
  logic               r_sign_a, r_sign_b, r_dz;
  logic [WIDTH-1:0]   r_res_lo, r_res_hi;
  logic               r_div_zero, r_unsup, r_flag_n, r_flag_z;

  logic               w_b_zero;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_acc_nxt;
  logic [WIDTH-1:0]   w_sr_nxt;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_fix_lo, w_fix_hi;
  logic               w_long, w_flag_n, w_flag_z;

  assign w_b_zero = (b == '0);
  assign w_mag_a  = (op_is_signed(op) && a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (op_is_signed(op) && b[WIDTH-1]) ? -b : b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div (op_is_div(r_op)),
    .i_acc (r_acc),
    .i_sr  (r_sr),
    .i_opd (r_opd),
    .o_acc (w_acc_nxt),
    .o_sr  (w_sr_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; div-by-zero skips RUN, unsupported ops skip to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (!op_supported(op))                w_state_nxt = ST_DONE;
          else if (op_is_div(op) && w_b_zero)   w_state_nxt = ST_FIX;
          else                                  w_state_nxt = ST_RUN;
        end
      end
      ST_RUN:  if (r_cnt == '0) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Final results: SMULL/SDIV sign fix-up, divide-by-zero values, flags.
  always_comb begin
    w_prod     = {r_acc[WIDTH-1:0], r_sr};
    w_prod_fix = w_prod;
    if ((r_op == OP_SMULL) && (r_sign_a != r_sign_b)) w_prod_fix = -w_prod;
    w_fix_lo = '0;
    w_fix_hi = '0;
    w_long   = 1'b0;
    case (r_op)
      OP_MUL: w_fix_lo = w_prod[WIDTH-1:0];
      OP_UMULL, OP_SMULL: begin
        {w_fix_hi, w_fix_lo} = w_prod_fix;
        w_long               = 1'b1;
      end
      default: begin
        if (r_dz) begin
          // r_sr holds the raw dividend when the divisor was zero
          w_fix_lo = '1;
          w_fix_hi = r_sr;
        end else begin
          w_fix_lo = r_sr;
          w_fix_hi = r_acc[WIDTH-1:0];
`ifdef MULDIV_SIGNED_DIV_EN
          if (r_op == OP_SDIV) begin
            if (r_sign_a ^ r_sign_b) w_fix_lo = -r_sr;
            if (r_sign_a)            w_fix_hi = -r_acc[WIDTH-1:0];
          end
`endif
        end
      end
    endcase
    w_flag_n = w_long ? w_fix_hi[WIDTH-1] : w_fix_lo[WIDTH-1];
    w_flag_z = w_long ? ({w_fix_hi, w_fix_lo} == '0) : (w_fix_lo == '0);
  end

  // Operand latch, iteration datapath/counter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_acc      <= '0;
      r_sr       <= '0;
      r_opd      <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_dz       <= 1'b0;
      r_res_lo   <= '0;
      r_res_hi   <= '0;
      r_div_zero <= 1'b0;
      r_unsup    <= 1'b0;
      r_flag_n   <= 1'b0;
      r_flag_z   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_res_lo   <= '0;
            r_res_hi   <= '0;
            r_div_zero <= 1'b0;
            r_flag_n   <= 1'b0;
            r_flag_z   <= 1'b0;
            r_unsup    <= !op_supported(op);
            r_op       <= op;
            r_cnt      <= CNT_W'(WIDTH - 1);
            r_acc      <= '0;
            r_sign_a   <= a[WIDTH-1];
            r_sign_b   <= b[WIDTH-1];
            r_dz       <= op_is_div(op) && w_b_zero;
            if (op_is_div(op)) begin
              r_sr  <= w_b_zero ? a : w_mag_a;
              r_opd <= w_mag_b;
            end else begin
              r_sr  <= w_mag_b;
              r_opd <= w_mag_a;
            end
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          r_sr  <= w_sr_nxt;
          r_cnt <= r_cnt - 1'b1;
        end
        ST_FIX: begin
          r_res_lo   <= w_fix_lo;
          r_res_hi   <= w_fix_hi;
          r_div_zero <= r_dz;
          r_flag_n   <= w_flag_n;
          r_flag_z   <= w_flag_z;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign result_lo = r_res_lo;
  assign result_hi = r_res_hi;
  assign div_zero  = r_div_zero;
  assign unsup     = r_unsup;
  assign flag_n    = r_flag_n;
  assign flag_z    = r_flag_z;

endmodule
